// File: rtl/ipsxe_floating_point_round_pipe_v1_0_pkg.sv
// Shared rounding-mode encodings for every floating-point core that drives a
// rounding mode into a round pipe.
package ipsxe_floating_point_round_pipe_v1_0_pkg;

  localparam int unsigned RND_MODE_W = 3;

  typedef enum logic [RND_MODE_W-1:0] {
    MODE_RNE     = 3'd0,
    MODE_HALF_UP = 3'd1,
    MODE_TRUNC   = 3'd2,
    MODE_POS_INF = 3'd3,
    MODE_NEG_INF = 3'd4
  } rnd_mode_e;

endpackage

// File: rtl/ipsxe_floating_point_round_pipe_v1_0_if.sv
// Valid/ready handshake and data bus of the round pipe.
//   slave  : the round pipe (consumes i_* beats, produces o_* beats)
//   master : the surrounding logic / testbench
interface ipsxe_floating_point_round_pipe_v1_0_if #(
  parameter int unsigned W   = 23,
  parameter int unsigned RNE = 5
);
  import ipsxe_floating_point_round_pipe_v1_0_pkg::*;

  logic                  i_valid;
  logic                  o_ready;
  logic [W+RNE-1:0]      i_before_rnd;
  logic                  i_sign;
  logic [RND_MODE_W-1:0] i_rnd_mode;
  logic                  o_valid;
  logic                  i_ready;
  logic [W-1:0]          o_after_rnd;
  logic                  o_carry;
  logic                  o_inexact;

  modport slave (
    input  i_valid, i_before_rnd, i_sign, i_rnd_mode, i_ready,
    output o_ready, o_valid, o_after_rnd, o_carry, o_inexact
  );

  modport master (
    output i_valid, i_before_rnd, i_sign, i_rnd_mode, i_ready,
    input  o_ready, o_valid, o_after_rnd, o_carry, o_inexact
  );
endinterface

// File: rtl/ipsxe_floating_point_rnd_decide_v1_0.sv
// Combinational rounding decision: whether to add one ulp to the kept bits.
//   g, s, l     : guard, sticky and kept-lsb bits
//   sign        : 1 = negative, only used by the directed modes
//   mode        : rounding mode (5-7 behave as round-to-nearest-even)
//   increment_c : add one to the kept bits
module ipsxe_floating_point_rnd_decide_v1_0
  import ipsxe_floating_point_round_pipe_v1_0_pkg::*;
(
  input  logic                  g,
  input  logic                  s,
  input  logic                  l,
  input  logic                  sign,
  input  logic [RND_MODE_W-1:0] mode,
  output logic                  increment_c
);

  always_comb begin
    increment_c = 1'b0;
    case (mode)
      MODE_HALF_UP: increment_c = g;
      MODE_TRUNC:   increment_c = 1'b0;
      MODE_POS_INF: increment_c = (g | s) & ~sign;
      MODE_NEG_INF: increment_c = (g | s) & sign;
      default:      increment_c = g & (s | l);
    endcase
  end

endmodule

// File: rtl/ipsxe_floating_point_round_pipe_v1_0.sv
// Two-stage rounding pipeline with valid/ready flow control.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : i_valid/o_ready input beat {i_before_rnd, i_sign, i_rnd_mode},
//                  o_valid/i_ready output beat {o_after_rnd, o_carry, o_inexact}
// Stage 1 holds the kept bits, increment decision and inexact flag; stage 2
// holds the sum and carry. Both stages advance together on en.
module ipsxe_floating_point_round_pipe_v1_0
  import ipsxe_floating_point_round_pipe_v1_0_pkg::*;
#(
  parameter int unsigned W   = 23,
  parameter int unsigned RNE = 5
) (
  input  logic i_clk,
  input  logic i_rst,
  ipsxe_floating_point_round_pipe_v1_0_if.slave bus
);

  localparam int unsigned IW = W + RNE;
  localparam int unsigned SW = W + 1;

  logic [W-1:0] u_c;
  logic         g_c, s_c, inc_c, en_c;
  logic [SW-1:0] sum_c;

  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_u_q, s1_u_d;
  logic         s1_inc_q, s1_inc_d;
  logic         s1_inexact_q, s1_inexact_d;
  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] s2_sum_q, s2_sum_d;
  logic         s2_carry_q, s2_carry_d;
  logic         s2_inexact_q, s2_inexact_d;

  assign u_c = bus.i_before_rnd[IW-1:RNE];
  assign g_c = bus.i_before_rnd[RNE-1];
  assign s_c = |bus.i_before_rnd[RNE-2:0];

  ipsxe_floating_point_rnd_decide_v1_0 u_decide (
    .g           (g_c),
    .s           (s_c),
    .l           (u_c[0]),
    .sign        (bus.i_sign),
    .mode        (bus.i_rnd_mode),
    .increment_c (inc_c)
  );

  // Whole pipe moves when the output slot is empty or being drained.
  assign en_c  = ~s2_valid_q | bus.i_ready;
  assign sum_c = {1'b0, s1_u_q} + SW'(s1_inc_q);

  // Next-state for both stages; hold everything while stalled.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_u_d       = s1_u_q;
    s1_inc_d     = s1_inc_q;
    s1_inexact_d = s1_inexact_q;
    s2_valid_d   = s2_valid_q;
    s2_sum_d     = s2_sum_q;
    s2_carry_d   = s2_carry_q;
    s2_inexact_d = s2_inexact_q;
    if (en_c) begin
      s1_valid_d   = bus.i_valid;
      s1_u_d       = u_c;
      s1_inc_d     = inc_c;
      s1_inexact_d = g_c | s_c;
      s2_valid_d   = s1_valid_q;
      s2_sum_d     = sum_c[W-1:0];
      s2_carry_d   = sum_c[W];
      s2_inexact_d = s1_inexact_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q   <= 1'b0;
      s1_u_q       <= '0;
      s1_inc_q     <= 1'b0;
      s1_inexact_q <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_sum_q     <= '0;
      s2_carry_q   <= 1'b0;
      s2_inexact_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_u_q       <= s1_u_d;
      s1_inc_q     <= s1_inc_d;
      s1_inexact_q <= s1_inexact_d;
      s2_valid_q   <= s2_valid_d;
      s2_sum_q     <= s2_sum_d;
      s2_carry_q   <= s2_carry_d;
      s2_inexact_q <= s2_inexact_d;
    end
  end

  // o_ready is forced low while reset is held so every output reads 0.
  assign bus.o_ready     = en_c & ~i_rst;
  assign bus.o_valid     = s2_valid_q;
  assign bus.o_after_rnd = s2_sum_q;
  assign bus.o_carry     = s2_carry_q;
  assign bus.o_inexact   = s2_inexact_q;

endmodule

// File: tb/tb_ipsxe_floating_point_round_pipe_v1_0.sv
// Directed self-checking bench for the rounding pipeline.
module tb_ipsxe_floating_point_round_pipe_v1_0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   fails = 0;

  ipsxe_floating_point_round_pipe_v1_0_if #(.W(23), .RNE(5)) bus ();

  ipsxe_floating_point_round_pipe_v1_0 #(.W(23), .RNE(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated beat: checks 2-cycle latency and the rounded result.
  task automatic run_one(input string tag, input logic [22:0] u, input logic [4:0] low,
                         input logic sign, input logic [2:0] mode,
                         input logic [22:0] exp_r, input logic exp_c, input logic exp_x);
    @(negedge clk);
    bus.i_valid      = 1'b1;
    bus.i_before_rnd = {u, low};
    bus.i_sign       = sign;
    bus.i_rnd_mode   = mode;
    bus.i_ready      = 1'b1;
    #1;
    chk({tag, "_oready"}, 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    #1;
    chk({tag, "_early"}, 32'(bus.o_valid), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
    chk({tag, "_res"}, 32'(bus.o_after_rnd), 32'(exp_r));
    chk({tag, "_carry"}, 32'(bus.o_carry), 32'(exp_c));
    chk({tag, "_inexact"}, 32'(bus.o_inexact), 32'(exp_x));
  endtask

  logic [22:0] bp_u   [8] = '{23'h10, 23'h11, 23'h12, 23'h13, 23'h14, 23'h15, 23'h16, 23'h17};
  logic [22:0] bp_exp [8] = '{23'h10, 23'h12, 23'h12, 23'h14, 23'h14, 23'h16, 23'h16, 23'h18};

  initial begin
    int          sent;
    int          got;
    logic        stalled_prev;
    logic [22:0] held;

    bus.i_valid      = 1'b0;
    bus.i_before_rnd = '0;
    bus.i_sign       = 1'b0;
    bus.i_rnd_mode   = 3'd0;
    bus.i_ready      = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_res", 32'(bus.o_after_rnd), 32'd0);
    chk("rst_carry", 32'(bus.o_carry), 32'd0);
    chk("rst_inexact", 32'(bus.o_inexact), 32'd0);
    chk("rst_oready", 32'(bus.o_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_oready", 32'(bus.o_ready), 32'd1);

    // Tie to even, mode comparison, overflow, exact
    run_one("tie_even_lo", 23'h000002, 5'b10000, 1'b0, 3'd0, 23'h000002, 1'b0, 1'b1);
    run_one("tie_even_up", 23'h000003, 5'b10000, 1'b0, 3'd0, 23'h000004, 1'b0, 1'b1);
    run_one("half_up",     23'h000002, 5'b10000, 1'b0, 3'd1, 23'h000003, 1'b0, 1'b1);
    run_one("trunc",       23'h000002, 5'b10000, 1'b0, 3'd2, 23'h000002, 1'b0, 1'b1);
    run_one("pos_inf",     23'h000002, 5'b10000, 1'b0, 3'd3, 23'h000003, 1'b0, 1'b1);
    run_one("neg_inf_pos", 23'h000002, 5'b10000, 1'b0, 3'd4, 23'h000002, 1'b0, 1'b1);
    run_one("neg_inf_neg", 23'h000002, 5'b00001, 1'b1, 3'd4, 23'h000003, 1'b0, 1'b1);
    run_one("pos_inf_neg", 23'h000002, 5'b00001, 1'b1, 3'd3, 23'h000002, 1'b0, 1'b1);
    run_one("mode5_tie",   23'h000002, 5'b10000, 1'b0, 3'd5, 23'h000002, 1'b0, 1'b1);
    run_one("mode7_tie",   23'h000003, 5'b10000, 1'b0, 3'd7, 23'h000004, 1'b0, 1'b1);
    run_one("below_half",  23'h000003, 5'b01111, 1'b0, 3'd0, 23'h000003, 1'b0, 1'b1);
    run_one("overflow",    23'h7FFFFF, 5'b11000, 1'b0, 3'd0, 23'h000000, 1'b1, 1'b1);
    run_one("exact",       23'h7FFFFF, 5'b00000, 1'b0, 3'd0, 23'h7FFFFF, 1'b0, 1'b0);

    // Backpressure: 8 back-to-back beats, i_ready low on cycles 3-6
    sent = 0;
    got = 0;
    stalled_prev = 1'b0;
    held = '0;
    bus.i_rnd_mode = 3'd0;
    bus.i_sign = 1'b0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      bus.i_ready = !(c >= 3 && c <= 6);
      if (sent < 8) begin
        bus.i_valid      = 1'b1;
        bus.i_before_rnd = {bp_u[sent], 5'b10000};
      end else begin
        bus.i_valid = 1'b0;
      end
      #1;
      if (stalled_prev) chk("bp_hold", 32'(bus.o_after_rnd), 32'(held));
      if (bus.o_valid && !bus.i_ready) begin
        chk("bp_oready_low", 32'(bus.o_ready), 32'd0);
        held = bus.o_after_rnd;
        stalled_prev = 1'b1;
      end else begin
        chk("bp_oready_high", 32'(bus.o_ready), 32'd1);
        stalled_prev = 1'b0;
      end
      if (bus.o_valid && bus.i_ready) begin
        chk("bp_data", 32'(bus.o_after_rnd), 32'(bp_exp[got]));
        got++;
      end
      if (bus.i_valid && bus.o_ready) sent++;
    end
    chk("bp_count", 32'(got), 32'd8);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("bp_no_dup", 32'(bus.o_valid), 32'd0);

    // Reset with two beats in flight
    @(negedge clk);
    bus.i_valid      = 1'b1;
    bus.i_before_rnd = {23'h40, 5'b00000};
    bus.i_rnd_mode   = 3'd2;
    @(negedge clk);
    bus.i_before_rnd = {23'h41, 5'b00000};
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("mid_rst_oready", 32'(bus.o_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("mid_rst_valid2", 32'(bus.o_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rel_oready", 32'(bus.o_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("flushed", 32'(bus.o_valid), 32'd0);
    end
    run_one("post_rst", 23'h000055, 5'b00000, 1'b0, 3'd0, 23'h000055, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
